// File: rtl/cpu_opponent_if.sv
// PLAYER2 turn handshake between the game controller (master) and the automatic opponent (slave).
interface cpu_opponent_if;
  logic       turn;
  logic [8:0] board_x;
  logic [8:0] board_o;
  logic       play2;
  logic [3:0] pos2;
  logic       busy;
  logic       no_move;

  modport master (
    output turn, board_x, board_o,
    input  play2, pos2, busy, no_move
  );

  modport slave (
    input  turn, board_x, board_o,
    output play2, pos2, busy, no_move
  );
endinterface

// File: rtl/cpu_opponent.sv
// Automatic tic-tac-toe PLAYER2: scans a board snapshot one line per cycle for a win,
// then a block, then falls back to a fixed-priority pick, and answers with a play2 pulse.
module cpu_opponent #(
  parameter bit BLOCK_EN = 1'b1
) (
  input logic           clock,
  input logic           reset,
  cpu_opponent_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN_WIN,
    ST_SCAN_BLOCK,
    ST_PICK,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [8:0] snap_x_q, snap_x_d;
  logic [8:0] snap_o_q, snap_o_d;
  logic [3:0] pos2_q, pos2_d;
  logic       no_move_q, no_move_d;

  logic [8:0] free;
  logic [8:0] scan_map;
  logic [3:0] ca, cb, cc;
  logic       hit_a, hit_b, hit_c, hit;
  logic [3:0] hit_cell;
  logic       pick_ok;
  logic [3:0] pick_cell;

  function automatic logic [11:0] line_cells(input logic [2:0] idx);
    case (idx)
      3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
      3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
      3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
      3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
      3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
      3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
      3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
      default: line_cells = {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  // A cell marked in both maps is treated as occupied.
  assign free     = ~(snap_x_q | snap_o_q);
  assign scan_map = (state_q == ST_SCAN_BLOCK) ? snap_x_q : snap_o_q;
  assign {ca, cb, cc} = line_cells(cnt_q);

  assign hit_a    = free[ca] & scan_map[cb] & scan_map[cc];
  assign hit_b    = free[cb] & scan_map[ca] & scan_map[cc];
  assign hit_c    = free[cc] & scan_map[ca] & scan_map[cb];
  assign hit      = hit_a | hit_b | hit_c;
  assign hit_cell = hit_a ? ca : (hit_b ? cb : cc);

  always_comb begin
    pick_ok   = 1'b1;
    pick_cell = 4'd0;
    if      (free[4]) pick_cell = 4'd4;
    else if (free[0]) pick_cell = 4'd0;
    else if (free[2]) pick_cell = 4'd2;
    else if (free[6]) pick_cell = 4'd6;
    else if (free[8]) pick_cell = 4'd8;
    else if (free[1]) pick_cell = 4'd1;
    else if (free[3]) pick_cell = 4'd3;
    else if (free[5]) pick_cell = 4'd5;
    else if (free[7]) pick_cell = 4'd7;
    else              pick_ok   = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      snap_x_q  <= 9'd0;
      snap_o_q  <= 9'd0;
      pos2_q    <= 4'd0;
      no_move_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      snap_x_q  <= snap_x_d;
      snap_o_q  <= snap_o_d;
      pos2_q    <= pos2_d;
      no_move_q <= no_move_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    snap_x_d  = snap_x_q;
    snap_o_d  = snap_o_q;
    pos2_d    = pos2_q;
    no_move_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.turn) begin
          snap_x_d = bus.board_x;
          snap_o_d = bus.board_o;
          cnt_d    = 3'd0;
          state_d  = ST_SCAN_WIN;
        end
      end
      ST_SCAN_WIN: begin
        if (!bus.turn) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          pos2_d  = hit_cell + 4'd1;
          state_d = ST_ISSUE;
        end else if (cnt_q == 3'd7) begin
          cnt_d   = 3'd0;
          state_d = BLOCK_EN ? ST_SCAN_BLOCK : ST_PICK;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_SCAN_BLOCK: begin
        if (!bus.turn) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          pos2_d  = hit_cell + 4'd1;
          state_d = ST_ISSUE;
        end else if (cnt_q == 3'd7) begin
          cnt_d   = 3'd0;
          state_d = ST_PICK;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_PICK: begin
        if (!bus.turn) begin
          state_d = ST_IDLE;
        end else if (pick_ok) begin
          pos2_d  = pick_cell + 4'd1;
          state_d = ST_ISSUE;
        end else begin
          no_move_d = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // Only a low turn releases the block, so a held turn never retriggers.
        if (!bus.turn) begin
          pos2_d  = 4'd0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.play2   = (state_q == ST_ISSUE);
    bus.busy    = (state_q != ST_IDLE);
    bus.pos2    = pos2_q;
    bus.no_move = no_move_q;
  end

endmodule

// File: tb/tb_cpu_opponent.sv
// Directed bench for cpu_opponent; cycle N is sampled on the falling edge before rising edge N,
// with cycle 0 being the rising edge that accepts turn.
module tb_cpu_opponent;

  logic clock = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  cpu_opponent_if bus ();
  cpu_opponent_if bus_nb ();

  cpu_opponent #(.BLOCK_EN(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  cpu_opponent #(.BLOCK_EN(1'b0)) dut_nb (
    .clock (clock),
    .reset (reset),
    .bus   (bus_nb)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Raises turn with the given board and reports the first play2/no_move cycle and the cycle after.
  task automatic run_move(input logic [8:0] bx, input logic [8:0] bo,
                          output int cyc, output logic [3:0] pos, output logic nm,
                          output logic p2_next, output logic nm_next, output logic [3:0] pos_next);
    bus.board_x = bx;
    bus.board_o = bo;
    bus.turn    = 1'b1;
    @(posedge clock);
    cyc = -1;
    pos = 4'd0;
    nm  = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (bus.play2 || bus.no_move) begin
        cyc = n;
        pos = bus.pos2;
        nm  = bus.no_move;
        break;
      end
    end
    @(negedge clock);
    p2_next  = bus.play2;
    nm_next  = bus.no_move;
    pos_next = bus.pos2;
  endtask

  task automatic release_turn();
    bus.turn = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.turn      = 1'b0;
    bus.board_x   = 9'd0;
    bus.board_o   = 9'd0;
    bus_nb.turn   = 1'b0;
    bus_nb.board_x = 9'd0;
    bus_nb.board_o = 9'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if ({bus.play2, bus.pos2, bus.busy, bus.no_move} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got play2=%b pos2=%0d busy=%b no_move=%b, expected all 0",
               bus.play2, bus.pos2, bus.busy, bus.no_move);
    end
    tests_run++;
    if ({bus_nb.play2, bus_nb.pos2, bus_nb.busy, bus_nb.no_move} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs_noblock: got play2=%b pos2=%0d busy=%b no_move=%b, expected all 0",
               bus_nb.play2, bus_nb.pos2, bus_nb.busy, bus_nb.no_move);
    end
  endtask

  task automatic test_win();
    int cyc; logic [3:0] pos, posn; logic nm, p2n, nmn; int extra;
    run_move(9'h018, 9'h003, cyc, pos, nm, p2n, nmn, posn);
    tests_run++;
    if (cyc !== 2 || pos !== 4'd3 || nm !== 1'b0) begin
      tests_failed++;
      $display("FAIL win_move: got cycle=%0d pos2=%0d no_move=%b, expected cycle=2 pos2=3 no_move=0", cyc, pos, nm);
    end
    tests_run++;
    if (p2n !== 1'b0 || posn !== 4'd3 || nmn !== 1'b0) begin
      tests_failed++;
      $display("FAIL win_hold: got play2=%b pos2=%0d no_move=%b after issue, expected 0/3/0", p2n, posn, nmn);
    end
    extra = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (bus.play2) extra++;
    end
    tests_run++;
    if (extra !== 0 || bus.pos2 !== 4'd3 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL win_no_retrigger: got extra_play2=%0d pos2=%0d busy=%b, expected 0/3/1", extra, bus.pos2, bus.busy);
    end
    release_turn();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.pos2 !== 4'd0) begin
      tests_failed++;
      $display("FAIL win_release: got busy=%b pos2=%0d, expected busy=0 pos2=0", bus.busy, bus.pos2);
    end
  endtask

  task automatic test_block();
    int cyc; logic [3:0] pos, posn; logic nm, p2n, nmn;
    run_move(9'h011, 9'h002, cyc, pos, nm, p2n, nmn, posn);
    tests_run++;
    if (cyc !== 16 || pos !== 4'd9 || nm !== 1'b0 || p2n !== 1'b0) begin
      tests_failed++;
      $display("FAIL block_diag: got cycle=%0d pos2=%0d no_move=%b play2_next=%b, expected 16/9/0/0", cyc, pos, nm, p2n);
    end
    release_turn();
    run_move(9'h003, 9'h000, cyc, pos, nm, p2n, nmn, posn);
    tests_run++;
    if (cyc !== 10 || pos !== 4'd3 || posn !== 4'd3) begin
      tests_failed++;
      $display("FAIL block_line0: got cycle=%0d pos2=%0d pos2_next=%0d, expected 10/3/3", cyc, pos, posn);
    end
    release_turn();
  endtask

  task automatic test_pick();
    int cyc; logic [3:0] pos, posn; logic nm, p2n, nmn;
    run_move(9'h000, 9'h000, cyc, pos, nm, p2n, nmn, posn);
    tests_run++;
    if (cyc !== 18 || pos !== 4'd5 || nm !== 1'b0) begin
      tests_failed++;
      $display("FAIL pick_center: got cycle=%0d pos2=%0d no_move=%b, expected 18/5/0", cyc, pos, nm);
    end
    release_turn();
    run_move(9'h010, 9'h000, cyc, pos, nm, p2n, nmn, posn);
    tests_run++;
    if (cyc !== 18 || pos !== 4'd1) begin
      tests_failed++;
      $display("FAIL pick_corner: got cycle=%0d pos2=%0d, expected 18/1", cyc, pos);
    end
    release_turn();
    run_move(9'h010, 9'h010, cyc, pos, nm, p2n, nmn, posn);
    tests_run++;
    if (cyc !== 18 || pos !== 4'd1) begin
      tests_failed++;
      $display("FAIL pick_double_occupied: got cycle=%0d pos2=%0d, expected 18/1", cyc, pos);
    end
    release_turn();
  endtask

  task automatic test_full_board();
    int cyc; logic [3:0] pos, posn; logic nm, p2n, nmn;
    run_move(9'h0D3, 9'h12C, cyc, pos, nm, p2n, nmn, posn);
    tests_run++;
    if (cyc !== 18 || nm !== 1'b1 || pos !== 4'd0) begin
      tests_failed++;
      $display("FAIL full_no_move: got cycle=%0d no_move=%b pos2=%0d, expected 18/1/0", cyc, nm, pos);
    end
    tests_run++;
    if (nmn !== 1'b0 || p2n !== 1'b0 || posn !== 4'd0 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_after: got no_move=%b play2=%b pos2=%0d busy=%b, expected 0/0/0/1", nmn, p2n, posn, bus.busy);
    end
    release_turn();
  endtask

  task automatic test_priority();
    int cyc; logic [3:0] pos, posn; logic nm, p2n, nmn;
    run_move(9'h000, 9'h00B, cyc, pos, nm, p2n, nmn, posn);
    tests_run++;
    if (cyc !== 2 || pos !== 4'd3) begin
      tests_failed++;
      $display("FAIL prio_lowest_line: got cycle=%0d pos2=%0d, expected 2/3", cyc, pos);
    end
    release_turn();
    run_move(9'h000, 9'h014, cyc, pos, nm, p2n, nmn, posn);
    tests_run++;
    if (cyc !== 9 || pos !== 4'd7) begin
      tests_failed++;
      $display("FAIL win_line7: got cycle=%0d pos2=%0d, expected 9/7", cyc, pos);
    end
    release_turn();
    run_move(9'h006, 9'h110, cyc, pos, nm, p2n, nmn, posn);
    tests_run++;
    if (cyc !== 8 || pos !== 4'd1) begin
      tests_failed++;
      $display("FAIL win_before_block: got cycle=%0d pos2=%0d, expected 8/1", cyc, pos);
    end
    release_turn();
  endtask

  task automatic test_abort();
    int cyc; logic [3:0] pos, posn; logic nm, p2n, nmn; int pulses; logic busy6; logic [3:0] pos_seen;
    bus.board_x = 9'h000;
    bus.board_o = 9'h000;
    bus.turn    = 1'b1;
    @(posedge clock);
    pulses   = 0;
    busy6    = 1'b1;
    pos_seen = 4'd0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (bus.play2 || bus.no_move) pulses++;
      pos_seen = pos_seen | bus.pos2;
      if (n == 6) busy6 = bus.busy;
      if (n == 5) bus.turn = 1'b0;
    end
    tests_run++;
    if (busy6 !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: got busy=%b at cycle 6, expected 0", busy6);
    end
    tests_run++;
    if (pulses !== 0 || pos_seen !== 4'd0) begin
      tests_failed++;
      $display("FAIL abort_silent: got pulses=%0d pos2_or=%0d, expected 0/0", pulses, pos_seen);
    end
    run_move(9'h000, 9'h000, cyc, pos, nm, p2n, nmn, posn);
    tests_run++;
    if (cyc !== 18 || pos !== 4'd5) begin
      tests_failed++;
      $display("FAIL abort_reraise: got cycle=%0d pos2=%0d, expected 18/5", cyc, pos);
    end
    release_turn();
  endtask

  task automatic test_reset_mid();
    int cyc; logic [3:0] pos; logic [6:0] outs13;
    bus.board_x = 9'h000;
    bus.board_o = 9'h000;
    bus.turn    = 1'b1;
    @(posedge clock);
    cyc    = -1;
    pos    = 4'd0;
    outs13 = 7'h7F;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clock);
      if (n == 13) begin
        outs13 = {bus.play2, bus.pos2, bus.busy, bus.no_move};
        reset  = 1'b0;
      end
      if (n == 12) reset = 1'b1;
      if (bus.play2 && cyc < 0) begin
        cyc = n;
        pos = bus.pos2;
      end
    end
    tests_run++;
    if (outs13 !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got {play2,pos2,busy,no_move}=%b, expected 0", outs13);
    end
    tests_run++;
    if (cyc !== 31 || pos !== 4'd5) begin
      tests_failed++;
      $display("FAIL reset_mid_restart: got cycle=%0d pos2=%0d, expected 31/5", cyc, pos);
    end
    release_turn();
  endtask

  task automatic test_back_to_back();
    int cyc; logic [3:0] pos, posn; logic nm, p2n, nmn;
    run_move(9'h018, 9'h003, cyc, pos, nm, p2n, nmn, posn);
    release_turn();
    run_move(9'h018, 9'h003, cyc, pos, nm, p2n, nmn, posn);
    tests_run++;
    if (cyc !== 2 || pos !== 4'd3) begin
      tests_failed++;
      $display("FAIL back_to_back: got cycle=%0d pos2=%0d, expected 2/3", cyc, pos);
    end
    release_turn();
  endtask

  task automatic test_no_block();
    int cyc; logic [3:0] pos;
    bus_nb.board_x = 9'h011;
    bus_nb.board_o = 9'h002;
    bus_nb.turn    = 1'b1;
    @(posedge clock);
    cyc = -1;
    pos = 4'd0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if ((bus_nb.play2 || bus_nb.no_move) && cyc < 0) begin
        cyc = n;
        pos = bus_nb.pos2;
      end
    end
    tests_run++;
    if (cyc !== 10 || pos !== 4'd3) begin
      tests_failed++;
      $display("FAIL noblock_pick: got cycle=%0d pos2=%0d, expected 10/3", cyc, pos);
    end
    bus_nb.turn = 1'b0;
    @(negedge clock);
    tests_run++;
    if (bus_nb.busy !== 1'b0 || bus_nb.pos2 !== 4'd0) begin
      tests_failed++;
      $display("FAIL noblock_release: got busy=%b pos2=%0d, expected 0/0", bus_nb.busy, bus_nb.pos2);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_win();
    test_block();
    test_pick();
    test_full_board();
    test_priority();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_no_block();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cpu_opponent.md
# cpu_opponent

Automatic PLAYER2 for the tic-tac-toe game. While the game controller sits in its PLAYER2 state, this block scans the current board and picks a move. It then returns the move to the controller as a one-cycle `play2` pulse with a cell position. It is the responder side of the controller's PLAYER2 turn handshake, and it replaces the second human's switch/button input.

## Interface
Parameters:
- `BLOCK_EN`, default 1: 1 enables the "block opponent's line" scan; 0 skips it.

Ports:
- `clock`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `turn`  input  1  high while the controller waits for PLAYER2's move.
- `board_x`  input  9  occupancy of player (X) cells; bit i = cell i, cells numbered row-major 0..8.
- `board_o`  input  9  occupancy of PLAYER2 (O) cells, same numbering.
- `play2`  output  1  one-cycle pulse: the move on `pos2` is valid.
- `pos2`  output  4  chosen cell, encoded 1..9 (cell index + 1); 0 when no move is held.
- `busy`  output  1  high from turn acceptance until the block returns to IDLE.
- `no_move`  output  1  one-cycle pulse: the board is full and no move can be made.

## Operation
- Reset values: `play2`=0, `pos2`=0, `busy`=0, `no_move`=0, state IDLE, line counter 0.
- A cell is free when `board_x[i]|board_o[i]`=0. A cell set in both maps counts as occupied.
- Lines are indexed 0..7 as follows:
  - rows: (0,1,2), (3,4,5), (6,7,8)
  - columns: (0,3,6), (1,4,7), (2,5,8)
  - diagonals: (0,4,8), (2,4,6)
- A line "hits" for map M when two of its cells are in M and the third is free. The hit cell is that free cell.

States:
- **IDLE**: if `turn`=1, snapshot `board_x`/`board_o` into internal registers, clear the line counter, and go to SCAN_WIN. All later decisions use the snapshot only.
- **SCAN_WIN**: evaluate one line per cycle against the O snapshot.
  - On a hit, latch the hit cell and go to ISSUE.
  - After line 7 with no hit, go to SCAN_BLOCK if `BLOCK_EN`=1, else PICK. The counter resets to 0.
- **SCAN_BLOCK**: same evaluation against the X snapshot.
  - On a hit, go to ISSUE.
  - After line 7 with no hit, go to PICK.
- **PICK**: one cycle, fixed priority: center 4, then corners 0, 2, 6, 8, then edges 1, 3, 5, 7.
  - If a free cell is found, latch it and go to ISSUE.
  - If none is free, pulse `no_move` and go to WAIT.
- **ISSUE**: drive `play2`=1 for exactly one cycle, with `pos2` = latched cell + 1. Go to WAIT.
- **WAIT**: `pos2` is held. When `turn`=0, clear `pos2` and go to IDLE.

Lowest line index wins when several lines hit in the same scan.

Abort: if `turn` falls during SCAN_WIN, SCAN_BLOCK or PICK, return to IDLE next cycle.
- No `play2` or `no_move` pulse is issued.
- `pos2` stays 0.

`busy`=1 in every state except IDLE.

`reset`=1 in any state forces the reset values on the next edge and has priority over every other transition. A pending move is discarded.

## Timing
Cycle 0 is the edge where IDLE samples `turn`=1.
- SCAN_WIN line k is evaluated in cycle 1+k. A hit gives `play2` in cycle 2+k.
- SCAN_BLOCK line k is evaluated in cycle 9+k. A hit gives `play2` in cycle 10+k.
- PICK runs in cycle 17. `play2` or `no_move` follows in cycle 18.
- With `BLOCK_EN`=0, PICK runs in cycle 9 and the result follows in cycle 10.
- Worst-case latency is 18 cycles. At most one `play2` is issued per `turn` high period.
- `turn` held high after ISSUE never retriggers a move. A new move requires `turn` to go 0 and then 1.
- `turn` rising in the same cycle that WAIT exits is not accepted. IDLE samples it on the following cycle.

## Test plan
- Win: `board_o`=9'h003, `board_x`=9'h018, `turn` held 1 → `play2` high in cycle 2 only, `pos2`=3.
- Block: `board_x`=9'h011, `board_o`=9'h002 → no win; block hit on line 6, `play2` in cycle 16, `pos2`=9.
- Empty board, `turn`=1 → `play2` in cycle 18, `pos2`=5. With `board_x`=9'h010 on the next turn → no hits, `pos2`=1.
- Full board: `board_x`=9'h0D3 and `board_o`=9'h12C, so every cell is occupied → `no_move` pulses in cycle 18; `play2` stays 0 and `pos2` stays 0.
- Reset at cycle 12 during SCAN_BLOCK → cycle 13: all outputs 0, `busy`=0. With `turn` kept high, a new scan starts at cycle 13 and `play2` appears at cycle 31 (empty board).
- `turn` dropped at cycle 5 → IDLE at cycle 6. No `play2` or `no_move` is issued. After a re-raise, the result arrives with full latency.
